// File: rtl/load_unit_pkg.sv
// Shared types and constants for the MEM-stage load unit: datapath widths,
// load op encodings and FSM states.
package load_unit_pkg;

  localparam int PROC_BITS = 32;
  localparam int ADDR_BITS = 32;

  typedef enum logic [2:0] {
    LOAD_BYTE   = 3'b000,
    LOAD_HALF   = 3'b001,
    LOAD_WORD   = 3'b011,
    LOAD_BYTE_U = 3'b100,
    LOAD_HALF_U = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic [ADDR_BITS-1:0] word_align(input logic [ADDR_BITS-1:0] addr);
    return {addr[ADDR_BITS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, data-memory and writeback signals of the load unit, bundled with
// modports for the unit (slave) and its environment (master).
interface load_unit_if;
  import load_unit_pkg::*;

  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [ADDR_BITS-1:0] i_addr;
  logic [2:0]           i_ls_filter_op;
  logic                 o_mem_re;
  logic [ADDR_BITS-1:0] o_mem_addr;
  logic [PROC_BITS-1:0] i_mem_rdata;
  logic                 o_valid;
  logic                 i_wb_ready;
  logic [PROC_BITS-1:0] o_data;
  logic                 o_misalign;

  modport slave (
    input  i_req_valid, i_addr, i_ls_filter_op, i_mem_rdata, i_wb_ready,
    output o_req_ready, o_mem_re, o_mem_addr, o_valid, o_data, o_misalign
  );

  modport master (
    output i_req_valid, i_addr, i_ls_filter_op, i_mem_rdata, i_wb_ready,
    input  o_req_ready, o_mem_re, o_mem_addr, o_valid, o_data, o_misalign
  );

endinterface

// File: rtl/load_unit_extract.sv
// Combinational lane select and sign/zero extension of a loaded word.
// LOAD_MISALIGN_TRAP_EN: flag misaligned half/word accesses and zero the result.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [PROC_BITS-1:0] i_word,
  input  logic [1:0]           i_offset,
  input  logic [2:0]           i_op,
  output logic [PROC_BITS-1:0] o_data,
  output logic                 o_misalign
);

  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [PROC_BITS-1:0] ext;
  logic                 misalign;

  // Little-endian lanes; half select looks only at offset[1], so addr[0] is dropped.
  assign byte_sel = i_word[{i_offset, 3'b000} +: 8];
  assign half_sel = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    ext      = i_word;
    misalign = 1'b0;
    case (i_op)
      LOAD_BYTE:   ext = {{24{byte_sel[7]}}, byte_sel};
      LOAD_BYTE_U: ext = {24'b0, byte_sel};
      LOAD_HALF: begin
        ext = {{16{half_sel[15]}}, half_sel};
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign = i_offset[0];
`endif
      end
      LOAD_HALF_U: begin
        ext = {16'b0, half_sel};
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign = i_offset[0];
`endif
      end
      // Undefined op codes fall through here and behave as LW.
      default: begin
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign = |i_offset;
`endif
      end
    endcase
  end

  assign o_data     = misalign ? '0 : ext;
  assign o_misalign = misalign;

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: accepts one load, issues a word read, extracts and
// extends the addressed lanes, and holds the result for WB (valid/ready).
module load_unit
  import load_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  load_unit_if.slave  bus
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [1:0]           off_q, off_d;
  logic                 valid_q, valid_d;
  logic [PROC_BITS-1:0] data_q, data_d;
  logic                 misalign_q, misalign_d;

  logic                 req_ready;
  logic                 accept;
  logic [PROC_BITS-1:0] ext_data;
  logic                 ext_misalign;

  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.i_wb_ready);
  assign accept    = bus.i_req_valid & req_ready;

  assign bus.o_req_ready = req_ready;
  assign bus.o_mem_re    = accept;
  assign bus.o_mem_addr  = word_align(bus.i_addr);
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_misalign  = misalign_q;

  load_extract u_extract (
    .i_word     (bus.i_mem_rdata),
    .i_offset   (off_q),
    .i_op       (op_q),
    .o_data     (ext_data),
    .o_misalign (ext_misalign)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    valid_d    = valid_q;
    data_d     = data_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        state_d    = ST_RESP;
        valid_d    = 1'b1;
        data_d     = ext_data;
        misalign_d = ext_misalign;
      end
      // Memory data is only sampled in WAIT; a stalled RESP holds its result.
      ST_RESP: begin
        if (bus.i_wb_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_WAIT;
      op_d    = bus.i_ls_filter_op;
      off_d   = bus.i_addr[1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      off_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected results are queued as loads are
// issued and compared as WB consumes them; honours LOAD_MISALIGN_TRAP_EN.
module tb_load_unit;
  import load_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_unit_if bus ();

  load_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [32:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] mem_word;
  bit          valid_prev;

  always @(posedge clk) cyc++;

  // Memory answers one cycle after a read; any other cycle returns junk.
  always @(posedge clk) bus.i_mem_rdata <= bus.o_mem_re ? mem_word : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: {misalign, data} for a load of word w at byte offset off.
  function automatic logic [32:0] model(input logic [31:0] w, input logic [1:0] off,
                                        input logic [2:0] op);
    logic [31:0] r;
    logic        mis;
    mis = 1'b0;
    case (op)
      3'b000, 3'b100: begin
        r = (w >> (int'(off) * 8)) & 32'h0000_00FF;
        if (op == 3'b000 && r[7]) r = r | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
`ifdef LOAD_MISALIGN_TRAP_EN
        mis = off[0];
`endif
        r = (w >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
        if (op == 3'b001 && r[15]) r = r | 32'hFFFF_0000;
      end
      default: begin
`ifdef LOAD_MISALIGN_TRAP_EN
        mis = (off != 2'b00);
`endif
        r = w;
      end
    endcase
    if (mis) r = 32'h0;
    return {mis, r};
  endfunction

  // Monitor: handshake, latency and result checks, sampled on the falling edge.
  always @(negedge clk) begin
    logic        acc;
    logic [32:0] e;
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      acc = bus.i_req_valid && bus.o_req_ready;
      check("mem_re", 32'(bus.o_mem_re), 32'(acc));
      if (acc) check("mem_addr", bus.o_mem_addr, bus.i_addr & 32'hFFFF_FFFC);
      if (bus.o_valid && !valid_prev) begin
        if (acc_q.size() == 0) check("valid_without_req", 32'(bus.o_valid), 32'h0);
        else check("latency", 32'(cyc - acc_q[0]), 32'd2);
      end
      if (bus.o_valid && bus.i_wb_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(bus.o_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          check("data", bus.o_data, e[31:0]);
          check("misalign", 32'(bus.o_misalign), 32'(e[32]));
        end
      end
      if (acc) acc_q.push_back(cyc);
      valid_prev = bus.o_valid;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] word);
    bit accepted;
    accepted = 1'b0;
    mem_word = word;
    exp_q.push_back(model(word, addr[1:0], op));
    bus.i_addr         = addr;
    bus.i_ls_filter_op = op;
    bus.i_req_valid    = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.o_req_ready;
      @(posedge clk);
      #1;
    end
    bus.i_req_valid = 1'b0;
    if (!accepted) begin
      check("accept_timeout", 32'(bus.o_req_ready), 32'h1);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst                = 1'b1;
    bus.i_req_valid    = 1'b0;
    bus.i_addr         = '0;
    bus.i_ls_filter_op = '0;
    bus.i_wb_ready     = 1'b1;
    mem_word           = '0;

    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_data", bus.o_data, 32'h0);
    check("rst_misalign", 32'(bus.o_misalign), 32'h0);
    check("rst_ready", 32'(bus.o_req_ready), 32'h1);
    check("rst_mem_re", 32'(bus.o_mem_re), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back loads with WB always ready.
    send(32'h1000_0001, LOAD_BYTE,   32'h1234_C9AB);
    send(32'h1000_0005, LOAD_BYTE_U, 32'h1234_C9AB);
    send(32'h1000_000A, LOAD_HALF_U, 32'h1234_C9AB);
    send(32'h1000_0000, LOAD_HALF,   32'h1234_C9AB);
    send(32'h1000_0003, LOAD_BYTE,   32'h80FF_7F01);
    send(32'h1000_0006, LOAD_BYTE_U, 32'h00FF_0000);
    send(32'h1000_0003, LOAD_HALF,   32'h8001_7FFF);
    send(32'h1000_0001, LOAD_HALF_U, 32'hABCD_8765);
    send(32'h1000_0000, 3'b010,      32'hCAFE_F00D);
    send(32'h1000_0004, 3'b111,      32'h0BAD_F00D);
    send(32'h1000_0002, LOAD_WORD,   32'h1234_C9AB);
    drain();

    // WB stall: result must hold and a waiting request must not be taken.
    bus.i_wb_ready = 1'b0;
    send(32'h2000_0000, LOAD_WORD, 32'h1234_C9AB);
    fork
      send(32'h2000_0006, LOAD_HALF_U, 32'h5A5A_F00F);
      begin
        @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", 32'(bus.o_valid), 32'h1);
          check("stall_data", bus.o_data, 32'h1234_C9AB);
          check("stall_ready", 32'(bus.o_req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.i_wb_ready = 1'b1;
      end
    join
    drain();

    // Reset while a load sits in WAIT: result must be discarded.
    send(32'h3000_0000, LOAD_WORD, 32'h1111_2222);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("wait_rst_data", bus.o_data, 32'h0);
    check("wait_rst_ready", 32'(bus.o_req_ready), 32'h1);
    repeat (3) begin
      check("wait_rst_valid", 32'(bus.o_valid), 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    send(32'h3000_0002, LOAD_BYTE, 32'h0080_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
